// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_t              : scheduler FSM encoding (IDLE / START / WAIT)
//   DEF_NUM_REQ          : default number of byte sources
//   DEF_CLKS_PER_BIT     : default clk cycles per baud tick (transmitter divider)
//   DEF_FRAME_TICKS      : default baud ticks waited after the start pulse
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_CLKS_PER_BIT = 10416;
  localparam int DEF_FRAME_TICKS  = 12;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational rotate-priority search.
//   req     : request vector, one bit per source
//   pointer : index of the last winner; search starts at pointer+1
//   winner  : first requesting index found searching upward (mod NUM_REQ)
//   valid   : 1 when any request bit is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a value held, which would infer a latch.
    winner = '0;
    valid  = 1'b0;
    // Walk from the farthest candidate toward pointer+1; the last hit
    // written is the closest one, i.e. the highest-priority requester.
    for (int i = NUM_REQ; i >= 1; i--) begin
      int idx;
      idx = int'(pointer) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        winner = PTR_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART transmitter between NUM_REQ byte sources with
// round-robin arbitration. The transmitter exposes no busy/done, so the
// frame is timed locally: tx_start is held for one full baud period, then
// FRAME_TICKS baud periods are waited before the next grant.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   enable   : 1 = new grants allowed; 0 = finish current frame, then hold
//   req      : per-source byte-valid
//   req_data : byte i at [8*i+7:8*i]
//   ack      : one-cycle pulse, byte i accepted
//   tx_start : to transmitter 'transmit'
//   tx_data  : to transmitter 'data', stable from grant to next grant
//   busy     : 1 whenever not IDLE
//   grant_id : index of the last requester granted
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
  parameter int PTR_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [PTR_W-1:0]     grant_id
);

  localparam int CNT_W = $clog2(FRAME_TICKS * CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(FRAME_TICKS * CLKS_PER_BIT - 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [PTR_W-1:0]   grant_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               tx_start_d;
  logic [7:0]         tx_data_d;

  logic [PTR_W-1:0]   arb_winner;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (req),
    .pointer (ptr),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ptr_d      = ptr;
    grant_d    = grant_id;
    tx_data_d  = tx_data;
    ack_d      = '0;
    tx_start_d = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable && arb_valid) begin
          tx_data_d         = req_data[8*int'(arb_winner) +: 8];
          grant_d           = arb_winner;
          ptr_d             = arb_winner;
          ack_d[arb_winner] = 1'b1;
          tx_start_d        = 1'b1;
          cnt_d             = '0;
          state_d           = ST_START;
        end
      end
      ST_START: begin
        // tx_start was raised on the grant edge; it stays up for exactly
        // CLKS_PER_BIT cycles so the transmitter sees it on one baud tick.
        if (cnt == START_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          tx_start_d = 1'b1;
          cnt_d      = cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The RR pointer resets to the last index so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ptr      <= PTR_W'(NUM_REQ - 1);
      grant_id <= '0;
      tx_data  <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state    <= state_d;
      cnt      <= cnt_d;
      ptr      <= ptr_d;
      grant_id <= grant_d;
      tx_data  <= tx_data_d;
      ack      <= ack_d;
      tx_start <= tx_start_d;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
